// File: rtl/multi_point_tracker.sv
// Per-channel centroid tracker: accumulates hit counts and coordinate sums over a frame,
// then resolves every channel's centre with one shared restoring divider.
//
// state  | meaning
// IDLE   | waiting for start of frame; results held
// ACCUM  | summing masked pixels per channel
// DIV    | per channel: load, COORD_W x-bits, COORD_W y-bits, store
module multi_point_tracker #(
  parameter int COORD_W    = 10,
  parameter int N_CH       = 3,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_sof,
  input  logic                      i_eof,
  input  logic                      i_valid,
  input  logic [COORD_W-1:0]        i_x,
  input  logic [COORD_W-1:0]        i_y,
  input  logic [N_CH-1:0]           i_mask,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_CH-1:0]           o_found,
  output logic [N_CH*COORD_W-1:0]   o_center_x,
  output logic [N_CH*COORD_W-1:0]   o_center_y
);

  localparam int SUM_W = CNT_W + COORD_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = $clog2(COORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;

  localparam logic [1:0] P_LOAD  = 2'd0;
  localparam logic [1:0] P_X     = 2'd1;
  localparam logic [1:0] P_Y     = 2'd2;
  localparam logic [1:0] P_STORE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q  [N_CH];
  logic [CNT_W-1:0]   cnt_d  [N_CH];
  logic [SUM_W-1:0]   sumx_q [N_CH];
  logic [SUM_W-1:0]   sumx_d [N_CH];
  logic [SUM_W-1:0]   sumy_q [N_CH];
  logic [SUM_W-1:0]   sumy_d [N_CH];
  logic [N_CH-1:0]    ovf_q, ovf_d;

  logic [1:0]         phase_q, phase_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [COORD_W-1:0] low_q, low_d;
  logic [COORD_W-1:0] quo_q, quo_d;
  logic [COORD_W-1:0] qx_q, qx_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               ok_q, ok_d;

  logic [COORD_W-1:0] resx_q [N_CH];
  logic [COORD_W-1:0] resx_d [N_CH];
  logic [COORD_W-1:0] resy_q [N_CH];
  logic [COORD_W-1:0] resy_d [N_CH];
  logic [N_CH-1:0]    fnd_q, fnd_d;

  logic                    done_q, done_d;
  logic [N_CH-1:0]         found_q, found_d;
  logic [N_CH*COORD_W-1:0] cx_q, cx_d;
  logic [N_CH*COORD_W-1:0] cy_q, cy_d;

  logic                    restart;
  logic                    accum_en;
  logic [CNT_W:0]          trial;
  logic                    trial_ge;
  logic [CNT_W-1:0]        rem_step;
  logic [COORD_W-1:0]      quo_step;
  logic [COORD_W-1:0]      low_step;
  logic                    ch_ok;

  // A new frame may start from IDLE or abort an ACCUM in progress; DIV ignores it.
  assign restart  = i_sof && (state_q != S_DIV);
  assign accum_en = restart || (state_q == S_ACCUM);

  // Remainder stays below the divisor, so one extra bit holds the trial value.
  assign trial    = {rem_q, low_q[COORD_W-1]};
  assign trial_ge = (trial >= {1'b0, div_q});
  assign rem_step = trial_ge ? CNT_W'(trial - {1'b0, div_q}) : trial[CNT_W-1:0];
  assign quo_step = {quo_q[COORD_W-2:0], trial_ge};
  assign low_step = {low_q[COORD_W-2:0], 1'b0};
  assign ch_ok    = (32'(cnt_q[ch_q]) >= 32'(MIN_PIXELS)) && !ovf_q[ch_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sumx_d  = sumx_q;
    sumy_d  = sumy_q;
    ovf_d   = ovf_q;
    phase_d = phase_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    low_d   = low_q;
    quo_d   = quo_q;
    qx_d    = qx_q;
    div_d   = div_q;
    ok_d    = ok_q;
    resx_d  = resx_q;
    resy_d  = resy_q;
    fnd_d   = fnd_q;
    found_d = found_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    done_d  = 1'b0;

    for (int c = 0; c < N_CH; c++) begin
      if (restart) begin
        cnt_d[c]  = '0;
        sumx_d[c] = '0;
        sumy_d[c] = '0;
        ovf_d[c]  = 1'b0;
      end
      if (accum_en && i_valid && i_mask[c]) begin
        if (cnt_d[c] == '1) begin
          ovf_d[c] = 1'b1;
        end else begin
          cnt_d[c]  = cnt_d[c] + CNT_W'(1);
          sumx_d[c] = sumx_d[c] + SUM_W'(i_x);
          sumy_d[c] = sumy_d[c] + SUM_W'(i_y);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_sof) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (i_eof && !i_sof) begin
          state_d = S_DIV;
          phase_d = P_LOAD;
          ch_d    = '0;
        end
      end
      S_DIV: begin
        case (phase_q)
          P_LOAD: begin
            ok_d    = ch_ok;
            div_d   = ch_ok ? cnt_q[ch_q] : CNT_W'(1);
            rem_d   = ch_ok ? sumx_q[ch_q][SUM_W-1:COORD_W] : '0;
            low_d   = sumx_q[ch_q][COORD_W-1:0];
            quo_d   = '0;
            bit_d   = BIT_W'(COORD_W);
            phase_d = P_X;
          end
          P_X: begin
            rem_d = rem_step;
            low_d = low_step;
            quo_d = quo_step;
            bit_d = bit_q - BIT_W'(1);
            // Last x bit: latch x quotient and preload y so y also takes exactly COORD_W cycles.
            if (bit_q == BIT_W'(1)) begin
              qx_d    = quo_step;
              rem_d   = ok_q ? sumy_q[ch_q][SUM_W-1:COORD_W] : '0;
              low_d   = sumy_q[ch_q][COORD_W-1:0];
              quo_d   = '0;
              bit_d   = BIT_W'(COORD_W);
              phase_d = P_Y;
            end
          end
          P_Y: begin
            rem_d = rem_step;
            low_d = low_step;
            quo_d = quo_step;
            bit_d = bit_q - BIT_W'(1);
            if (bit_q == BIT_W'(1)) phase_d = P_STORE;
          end
          default: begin
            resx_d[ch_q] = ok_q ? qx_q : '0;
            resy_d[ch_q] = ok_q ? quo_q : '0;
            fnd_d[ch_q]  = ok_q;
            if (ch_q == CH_W'(N_CH - 1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              found_d = fnd_d;
              for (int c = 0; c < N_CH; c++) begin
                cx_d[c*COORD_W +: COORD_W] = resx_d[c];
                cy_d[c*COORD_W +: COORD_W] = resy_d[c];
              end
            end else begin
              ch_d    = ch_q + CH_W'(1);
              phase_d = P_LOAD;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ovf_q   <= '0;
      phase_q <= P_LOAD;
      ch_q    <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      low_q   <= '0;
      quo_q   <= '0;
      qx_q    <= '0;
      div_q   <= '0;
      ok_q    <= 1'b0;
      fnd_q   <= '0;
      done_q  <= 1'b0;
      found_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= '0;
        sumx_q[c] <= '0;
        sumy_q[c] <= '0;
        resx_q[c] <= '0;
        resy_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      phase_q <= phase_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      low_q   <= low_d;
      quo_q   <= quo_d;
      qx_q    <= qx_d;
      div_q   <= div_d;
      ok_q    <= ok_d;
      fnd_q   <= fnd_d;
      done_q  <= done_d;
      found_q <= found_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        sumx_q[c] <= sumx_d[c];
        sumy_q[c] <= sumy_d[c];
        resx_q[c] <= resx_d[c];
        resy_q[c] <= resy_d[c];
      end
    end
  end

  assign o_busy     = (state_q == S_DIV);
  assign o_done     = done_q;
  assign o_found    = found_q;
  assign o_center_x = cx_q;
  assign o_center_y = cy_q;

endmodule

// File: tb/tb_multi_point_tracker.sv
// Bench for multi_point_tracker: default instance plus a narrow-counter instance sharing stimulus;
// expected results are queued at end of frame and checked whenever o_done pulses.
module tb_multi_point_tracker;

  localparam int NC  = 3;
  localparam int LAT = 67;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sof, i_eof, i_valid;
  logic [9:0]  i_x, i_y;
  logic [2:0]  i_mask;

  logic        a_busy, a_done;
  logic [2:0]  a_found;
  logic [29:0] a_cx, a_cy;
  logic        b_busy, b_done;
  logic [2:0]  b_found;
  logic [29:0] b_cx, b_cy;

  multi_point_tracker dut_a (
    .clk(clk), .rst(rst), .i_sof(i_sof), .i_eof(i_eof), .i_valid(i_valid),
    .i_x(i_x), .i_y(i_y), .i_mask(i_mask),
    .o_busy(a_busy), .o_done(a_done), .o_found(a_found),
    .o_center_x(a_cx), .o_center_y(a_cy)
  );

  multi_point_tracker #(.CNT_W(4), .MIN_PIXELS(4)) dut_b (
    .clk(clk), .rst(rst), .i_sof(i_sof), .i_eof(i_eof), .i_valid(i_valid),
    .i_x(i_x), .i_y(i_y), .i_mask(i_mask),
    .o_busy(b_busy), .o_done(b_done), .o_found(b_found),
    .o_center_x(b_cx), .o_center_y(b_cy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          ecyc;
    logic [2:0]  f;
    logic [29:0] cx;
    logic [29:0] cy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model, index 0 = default instance, 1 = CNT_W=4/MIN_PIXELS=4 instance
  int  mcnt [2][NC];
  int  msx  [2][NC];
  int  msy  [2][NC];
  bit  movf [2][NC];
  bit  m_acc = 0;
  bit  m_div = 0;
  int  m_ecyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cw_of(input int d);
    return (d == 0) ? 19 : 4;
  endfunction

  function automatic int min_of(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) begin
        mcnt[d][c] = 0; msx[d][c] = 0; msy[d][c] = 0; movf[d][c] = 0;
      end
  endtask

  task automatic push_expected();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.ecyc = cyc; e.f = '0; e.cx = '0; e.cy = '0;
      for (int c = 0; c < NC; c++) begin
        if (mcnt[d][c] >= min_of(d) && !movf[d][c]) begin
          e.f[c] = 1'b1;
          e.cx[c*10 +: 10] = 10'(msx[d][c] / mcnt[d][c]);
          e.cy[c*10 +: 10] = 10'(msy[d][c] / mcnt[d][c]);
        end
      end
      if (d == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask

  // Drive one cycle of stimulus and advance the model for what the DUT should accept.
  task automatic drive(input bit sof, input bit eof, input bit valid,
                       input int x, input int y, input logic [2:0] mask);
    bit in_div;
    bit acc;
    i_sof = sof; i_eof = eof; i_valid = valid;
    i_x = 10'(x); i_y = 10'(y); i_mask = mask;
    in_div = m_div && (cyc < m_ecyc + LAT);
    if (!in_div) begin
      m_div = 0;
      acc = m_acc || sof;
      if (sof) model_clear();
      if (acc && valid) begin
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < NC; c++)
            if (mask[c]) begin
              if (mcnt[d][c] == (1 << cw_of(d)) - 1) movf[d][c] = 1;
              else begin
                mcnt[d][c]++; msx[d][c] += x; msy[d][c] += y;
              end
            end
      end
      if (acc) m_acc = 1;
      if (acc && eof && !sof) begin
        push_expected();
        m_div = 1; m_acc = 0; m_ecyc = cyc;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 3'b000);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < limit) begin
      drive(0, 0, 0, 0, 0, 3'b000);
      n++;
    end
    n_chk++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d required 0", q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    i_sof = 0; i_eof = 0; i_valid = 0; i_x = '0; i_y = '0; i_mask = '0;
    model_clear(); m_acc = 0; m_div = 0;
    q_a.delete(); q_b.delete();
    @(posedge clk); #1;
    chk({tag, "_a_busy"},  32'(a_busy),  0);
    chk({tag, "_a_done"},  32'(a_done),  0);
    chk({tag, "_a_found"}, 32'(a_found), 0);
    chk({tag, "_a_cx"},    32'(a_cx),    0);
    chk({tag, "_a_cy"},    32'(a_cy),    0);
    chk({tag, "_b_found"}, 32'(b_found), 0);
    chk({tag, "_b_cx"},    32'(b_cx),    0);
    rst = 1'b0;
  endtask

  // Monitors: pop and compare on every o_done
  exp_t e_a, e_b;
  bit   pb_a = 0, pb_b = 0;

  always @(negedge clk) begin
    if (!rst && a_done) begin
      if (q_a.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL a_unexpected_done: got done=1 at cycle %0d required none", cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("a_latency", 32'(cyc - e_a.ecyc), LAT);
        chk("a_found", 32'(a_found), 32'(e_a.f));
        chk("a_center_x", 32'(a_cx), 32'(e_a.cx));
        chk("a_center_y", 32'(a_cy), 32'(e_a.cy));
        chk("a_busy_at_done", 32'(a_busy), 0);
        chk("a_busy_before_done", 32'(pb_a), 1);
      end
    end
    pb_a = a_busy;
  end

  always @(negedge clk) begin
    if (!rst && b_done) begin
      if (q_b.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL b_unexpected_done: got done=1 at cycle %0d required none", cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("b_latency", 32'(cyc - e_b.ecyc), LAT);
        chk("b_found", 32'(b_found), 32'(e_b.f));
        chk("b_center_x", 32'(b_cx), 32'(e_b.cx));
        chk("b_center_y", 32'(b_cy), 32'(e_b.cy));
        chk("b_busy_at_done", 32'(b_busy), 0);
      end
    end
    pb_b = b_busy;
  end

  task automatic frame_block();
    drive(1, 0, 0, 0, 0, 3'b000);
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++)
        drive(0, 0, 1, x, y, 3'b001);
    drive(0, 1, 0, 0, 0, 3'b000);
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_found"}, 32'(a_found), 1);
    chk({tag, "_cx0"}, 32'(a_cx[9:0]), 101);
    chk({tag, "_cy0"}, 32'(a_cy[9:0]), 51);
    chk({tag, "_cx12"}, 32'(a_cx[29:10]), 0);
    chk({tag, "_cy12"}, 32'(a_cy[29:10]), 0);
    chk({tag, "_b_found_ovf"}, 32'(b_found), 0);
  endtask

  initial begin
    rst = 1'b1;
    i_sof = 0; i_eof = 0; i_valid = 0; i_x = '0; i_y = '0; i_mask = '0;
    @(posedge clk); #1;
    do_reset("reset");

    // Frame A: 4x4 block on ch0
    frame_block();
    wait_drain(200);
    check_block("blockA");

    // Frame B: ch1 at both x extremes, ch2 one hit short of found; sof with pixel in IDLE
    drive(1, 0, 1, 0, 479, 3'b010);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 479, 3'b010);
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 200, 100, 3'b100);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 639, 479, 3'b010);
    drive(0, 1, 1, 639, 479, 3'b010);
    wait_drain(200);
    chk("edges_found", 32'(a_found), 2);
    chk("edges_cx1", 32'(a_cx[19:10]), 319);
    chk("edges_cy1", 32'(a_cy[19:10]), 479);
    chk("edges_cx2", 32'(a_cx[29:20]), 0);
    chk("edges_b_found", 32'(b_found), 4);
    chk("edges_b_cx2", 32'(b_cx[29:20]), 200);

    // Frame S: partial frame, then sof+eof+pixel restart, eof together with last pixel
    drive(1, 0, 1, 500, 400, 3'b111);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 300 + i, 200, 3'b111);
    drive(1, 1, 1, 10, 20, 3'b111);
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 10 + i, 20 + 2 * i, 3'b011);
    drive(0, 1, 1, 25, 50, 3'b011);
    wait_drain(200);
    chk("stress_found", 32'(a_found), 3);
    chk("stress_cx0", 32'(a_cx[9:0]), 17);
    chk("stress_cy0", 32'(a_cy[9:0]), 34);
    chk("stress_cx1", 32'(a_cx[19:10]), 17);

    // Frame C, then a whole extra frame pulsed while busy
    drive(1, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 60, 70, 3'b001);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 5 + i, 7 + i, 3'b100);
    drive(0, 1, 0, 0, 0, 3'b000);
    chk("busy_in_div", 32'(a_busy), 1);
    idle(10);
    drive(1, 0, 1, 1, 1, 3'b111);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 900, 900, 3'b111);
    drive(0, 1, 1, 900, 900, 3'b111);
    drive(1, 0, 0, 0, 0, 3'b000);
    wait_drain(200);
    chk("ignore_found", 32'(a_found), 4);
    chk("ignore_cx2", 32'(a_cx[29:20]), 14);
    chk("ignore_cy2", 32'(a_cy[29:20]), 16);
    chk("ignore_b_found", 32'(b_found), 1);
    chk("ignore_b_cx0", 32'(b_cx[9:0]), 60);
    idle(100);
    chk("idle_after_div", 32'(a_busy), 0);

    // Frame D aborted by reset 30 cycles into DIV; no done may follow
    frame_block();
    idle(30);
    chk("busy_before_rst", 32'(a_busy), 1);
    do_reset("midrst");
    idle(80);

    // Fresh frame after reset completes normally
    frame_block();
    wait_drain(200);
    check_block("blockE");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
